flitzip_compress_ctrl: RTL and testbench

//  Sequencing controller for the FlitZip base-delta flit compressor. Accepts one flit, scans its

---
 rtl/flitzip_compress_ctrl.sv | 161 ++++++++++++++++
 tb/tb_flitzip_compress_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flitzip_compress_ctrl.sv
// FlitZip base-delta compression sequencer: latches one flit, scans chunk min/max serially,
// picks base=(max+min)/2 and either packs per-chunk deltas or forwards the flit raw.
module flitzip_compress_ctrl #(
  parameter int INPUT_WIDTH  = 128,
  parameter int OUTPUT_WIDTH = 128,
  parameter int CHUNK_SIZE   = 8,
  parameter int DELTA_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    out_compressed,
  output logic                    busy,
  output logic [15:0]             comp_count
);

  localparam int NUM_CHUNKS = INPUT_WIDTH / CHUNK_SIZE;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [CHUNK_SIZE-1:0] DELTA_MAX = CHUNK_SIZE'((1 << (DELTA_BITS - 1)) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_BASE,
    S_PACK,
    S_EMIT
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CHUNK_SIZE-1:0]   min_q, min_d;
  logic [CHUNK_SIZE-1:0]   max_q, max_d;
  logic [CHUNK_SIZE-1:0]   base_q, base_d;
  logic [OUTPUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                    out_compressed_q, out_compressed_d;
  logic [15:0]             comp_count_q, comp_count_d;
  logic [INPUT_WIDTH-1:0]  flit_q;
  logic                    flit_load;

  logic [CHUNK_SIZE-1:0]   chunk;
  logic [CHUNK_SIZE:0]     sum;
  logic [CHUNK_SIZE-1:0]   base_w;
  logic                    compressible;
  logic [DELTA_BITS-1:0]   delta;

  // Datapath shared by SCAN/BASE/PACK; the one-bit-wider sum keeps (max+min)/2 exact.
  always_comb begin
    chunk        = flit_q[int'(idx_q)*CHUNK_SIZE +: CHUNK_SIZE];
    sum          = {1'b0, max_q} + {1'b0, min_q};
    base_w       = CHUNK_SIZE'(sum >> 1);
    compressible = (max_q - base_w) <= DELTA_MAX;
    delta        = DELTA_BITS'({1'b0, chunk} - {1'b0, base_q});
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    min_d            = min_q;
    max_d            = max_q;
    base_d           = base_q;
    data_out_d       = data_out_q;
    out_compressed_d = out_compressed_q;
    comp_count_d     = comp_count_q;
    flit_load        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          flit_load = 1'b1;
          idx_d     = '0;
          min_d     = '1;
          max_d     = '0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (chunk < min_q) min_d = chunk;
        if (chunk > max_q) max_d = chunk;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_BASE;
        end
      end
      S_BASE: begin
        base_d           = base_w;
        idx_d            = '0;
        out_compressed_d = 1'b0;
        if (compressible) begin
          data_out_d                   = '0;
          data_out_d[CHUNK_SIZE-1:0]   = base_w;
          state_d                      = S_PACK;
        end else begin
          data_out_d = OUTPUT_WIDTH'(flit_q);
          state_d    = S_EMIT;
        end
      end
      S_PACK: begin
        data_out_d[CHUNK_SIZE + int'(idx_q)*DELTA_BITS +: DELTA_BITS] = delta;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d            = '0;
          out_compressed_d = 1'b1;
          state_d          = S_EMIT;
        end
      end
      S_EMIT: begin
        // Output registers stay untouched here, so data holds for any out_ready stall.
        if (out_ready) begin
          state_d = S_IDLE;
          if (out_compressed_q && (comp_count_q != 16'hFFFF))
            comp_count_d = comp_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      min_q            <= '1;
      max_q            <= '0;
      base_q           <= '0;
      data_out_q       <= '0;
      out_compressed_q <= 1'b0;
      comp_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      min_q            <= min_d;
      max_q            <= max_d;
      base_q           <= base_d;
      data_out_q       <= data_out_d;
      out_compressed_q <= out_compressed_d;
      comp_count_q     <= comp_count_d;
    end
  end

  // NOTE: the flit holding register has no reset; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (flit_load) flit_q <= data_in;
  end

  assign in_ready       = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign out_valid      = (state_q == S_EMIT);
  assign data_out       = data_out_q;
  assign out_compressed = out_compressed_q;
  assign comp_count     = comp_count_q;

endmodule

// File: tb/tb_flitzip_compress_ctrl.sv
// Self-checking bench for flitzip_compress_ctrl: behavioural flit model plus a per-cycle
// compare process, directed corner flits and randomized traffic.
module tb_flitzip_compress_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;
  logic         out_compressed;
  logic         busy;
  logic [15:0]  comp_count;

  int checks = 0;
  int errors = 0;

  flitzip_compress_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_in        (data_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_out       (data_out),
    .out_compressed (out_compressed),
    .busy           (busy),
    .comp_count     (comp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: min/max over chunks, midpoint base, delta range test, packed image.
  function automatic void model_flit(input logic [127:0] f, output logic [127:0] d,
                                     output logic c);
    int mn, mx, b, ch;
    mn = 255;
    mx = 0;
    for (int i = 0; i < 16; i++) begin
      ch = int'(f[i*8 +: 8]);
      if (ch < mn) mn = ch;
      if (ch > mx) mx = ch;
    end
    b = (mn + mx) / 2;
    c = ((mx - b) <= 7);
    if (!c) begin
      d = f;
    end else begin
      d = '0;
      d[7:0] = 8'(b);
      for (int i = 0; i < 16; i++) begin
        ch = int'(f[i*8 +: 8]);
        d[8 + 4*i +: 4] = 4'((ch - b) & 15);
      end
    end
  endfunction

  // Model state, advanced on each rising edge from the bench-driven inputs only.
  logic         m_started = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_fresh = 1'b1;
  int           m_wait = 0;
  logic [127:0] m_data = '0;
  logic         m_comp = 1'b0;
  int           m_count = 0;

  initial forever begin
    @(posedge clk);
    m_started = 1'b1;
    if (rst) begin
      m_busy  = 1'b0;
      m_wait  = 0;
      m_count = 0;
      m_fresh = 1'b1;
    end else if (!m_busy) begin
      if (in_valid) begin
        model_flit(data_in, m_data, m_comp);
        m_busy  = 1'b1;
        m_fresh = 1'b0;
        m_wait  = m_comp ? 33 : 17;
      end
    end else if (m_wait == 0) begin
      if (out_ready) begin
        m_busy = 1'b0;
        if (m_comp && m_count < 65535) m_count++;
      end
    end else begin
      m_wait--;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      check("in_ready", 128'(in_ready), 128'(!m_busy));
      check("busy", 128'(busy), 128'(m_busy));
      check("out_valid", 128'(out_valid), 128'(m_busy && m_wait == 0));
      check("comp_count", 128'(comp_count), 128'(m_count));
      if (m_busy && m_wait == 0) begin
        check("data_out", data_out, m_data);
        check("out_compressed", 128'(out_compressed), 128'(m_comp));
      end else if (m_fresh) begin
        check("data_out_rst", data_out, 128'h0);
        check("out_compressed_rst", 128'(out_compressed), 128'h0);
      end
    end
  end

  task automatic send(input logic [127:0] f, input int stall, output logic [127:0] got,
                      output logic gotc, output int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 128'(in_ready), 128'h1);
    data_in  = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      in_valid = 1'($urandom);
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end while (!out_valid && lat < 100);
    check("emit_timeout", 128'(out_valid), 128'h1);
    got  = data_out;
    gotc = out_compressed;
    repeat (stall) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  function automatic logic [127:0] fill(input logic [7:0] v);
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = v;
    return f;
  endfunction

  logic [127:0] f, got, md;
  logic         gotc, mc;
  int           lat, b;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Pin the model with hand-derived values.
    model_flit(fill(8'h55), md, mc);
    check("model_equal", md, 128'h55);
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = (i % 2 == 0) ? 8'h10 : 8'h17;
    model_flit(f, md, mc);
    check("model_alt", md[71:0], 72'h4D4D_4D4D_4D4D_4D4D_13);

    // Equal chunks.
    send(fill(8'h55), 0, got, gotc, lat);
    check("t1_data", got, 128'h55);
    check("t1_comp", 128'(gotc), 128'h1);
    check("t1_lat", 128'(lat), 128'd33);

    // Alternating 10/17.
    send(f, 1, got, gotc, lat);
    check("t2_deltas", 128'(got[71:8]), 128'h4D4D_4D4D_4D4D_4D4D);
    check("t2_base", 128'(got[7:0]), 128'h13);
    check("t2_upper", 128'(got[127:72]), 128'h0);

    // Wide spread -> raw.
    f = fill(8'h80);
    f[7:0]  = 8'h00;
    f[15:8] = 8'hFF;
    send(f, 0, got, gotc, lat);
    check("t3_data", got, f);
    check("t3_comp", 128'(gotc), 128'h0);
    check("t3_lat", 128'(lat), 128'd17);

    // Range boundary: +7/-7 compresses, +8 does not.
    f = fill(8'h27);
    f[7:0]  = 8'h20;
    f[15:8] = 8'h2E;
    send(f, 0, got, gotc, lat);
    check("t4a_comp", 128'(gotc), 128'h1);
    check("t4a_base", 128'(got[7:0]), 128'h27);
    check("t4a_d01", 128'(got[15:8]), 128'h79);
    f[15:8] = 8'h2F;
    send(f, 0, got, gotc, lat);
    check("t4b_comp", 128'(gotc), 128'h0);
    check("t4b_data", got, f);

    // Backpressure: 5-cycle stall, count moves only on handshake.
    @(negedge clk);
    check("t5_count_before", 128'(comp_count), 128'd3);
    send(fill(8'h55), 5, got, gotc, lat);
    @(negedge clk);
    check("t5_count_after", 128'(comp_count), 128'd4);

    // Reset in the middle of PACK.
    data_in  = fill(8'h55);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_out_valid", 128'(out_valid), 128'h0);
    check("t6_busy", 128'(busy), 128'h0);
    check("t6_in_ready", 128'(in_ready), 128'h1);
    check("t6_count", 128'(comp_count), 128'h0);
    send(fill(8'h55), 0, got, gotc, lat);
    check("t6_data", got, 128'h55);
    check("t6_lat", 128'(lat), 128'd33);

    // Randomized traffic: fully random, near-boundary and tight clusters.
    for (int n = 0; n < 45; n++) begin
      b = int'($urandom_range(0, 255));
      for (int i = 0; i < 16; i++) begin
        case (n % 3)
          0:       f[i*8 +: 8] = 8'($urandom);
          1:       f[i*8 +: 8] = 8'(b + int'($urandom_range(0, 16)) - 8);
          default: f[i*8 +: 8] = 8'(b + int'($urandom_range(0, 14)));
        endcase
      end
      send(f, int'($urandom_range(0, 3)), got, gotc, lat);
      model_flit(f, md, mc);
      check("rand_lat", 128'(lat), mc ? 128'd33 : 128'd17);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
